// File: rtl/onchip_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : onchip_mem_pkg
// Purpose  : Shared definitions for the two-master on-chip RAM arbiter:
//            owner encoding, read-tag layout and default parameter values.
// Revision : 1.0 - initial release
// ============================================================================
package onchip_mem_pkg;

  // Default geometry of the shared RAM and the fairness window
  localparam int DEF_ADDR_W  = 12;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_DEPTH   = 3000;
  localparam int DEF_MAX_RUN = 4;

  // Who currently owns the RAM port (also used to encode a grant)
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  // One-deep tag describing the read whose data returns next cycle
  typedef struct packed {
    logic vld;  // a read was granted last cycle
    logic id;   // 0 = m0, 1 = m1
    logic oor;  // address was beyond the implemented words
  } rd_tag_t;

  // Bits needed to hold a run count of 0..max_run
  function automatic int run_width(input int max_run);
    return (max_run < 2) ? 1 : $clog2(max_run + 1);
  endfunction

endpackage : onchip_mem_pkg
`default_nettype wire

// File: rtl/onchip_mem_rr_grant.sv
`default_nettype none
// ============================================================================
// Module   : onchip_mem_rr_grant
// Purpose  : Grant decision for two masters sharing one RAM port. The
//            current owner keeps the port until it stops requesting or has
//            used MAX_RUN consecutive grants while the other master waits.
// Revision : 1.0 - initial release
// ============================================================================
module onchip_mem_rr_grant
  import onchip_mem_pkg::*;
#(
  parameter int MAX_RUN = DEF_MAX_RUN
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   req0_i,
  input  logic   req1_i,
  output owner_e grant_o
);

  localparam int              RUN_W   = run_width(MAX_RUN);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RUN);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  owner_e             owner_q, owner_d;
  logic [RUN_W-1:0]   run_q, run_d;
  owner_e             w_grant;
  logic               w_run_open;

  // The owner may continue while it has not yet exhausted its run window
  assign w_run_open = (run_q < RUN_MAX);

  // Combinational grant from the registered owner/run and live requests;
  // nothing is granted while reset is held
  always_comb begin
    w_grant = OWN_NONE;
    if (!reset) begin
      case (owner_q)
        OWN_M0: begin
          if (req0_i && (!req1_i || w_run_open)) w_grant = OWN_M0;
          else if (req1_i)                       w_grant = OWN_M1;
          else if (req0_i)                       w_grant = OWN_M0;
        end
        OWN_M1: begin
          if (req1_i && (!req0_i || w_run_open)) w_grant = OWN_M1;
          else if (req0_i)                       w_grant = OWN_M0;
          else if (req1_i)                       w_grant = OWN_M1;
        end
        default: begin
          // No owner: m0 wins a tie
          if (req0_i)      w_grant = OWN_M0;
          else if (req1_i) w_grant = OWN_M1;
        end
      endcase
    end
  end

  // Next owner/run: a repeat grant extends the run, a change restarts it
  always_comb begin
    owner_d = w_grant;
    run_d   = '0;
    if (w_grant != OWN_NONE) begin
      if (w_grant == owner_q) begin
        run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_ONE;
      end else begin
        run_d = RUN_ONE;
      end
    end
  end

  // Owner/run state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWN_NONE;
      run_q   <= '0;
    end else begin
      owner_q <= owner_d;
      run_q   <= run_d;
    end
  end

  assign grant_o = w_grant;

endmodule : onchip_mem_rr_grant
`default_nettype wire

// File: rtl/onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : onchip_mem_arbiter
// Purpose  : Lets two Avalon-style masters share one single-port on-chip
//            RAM with one-cycle read latency. Grants complete in the cycle
//            they are given; read data is routed back through a one-deep
//            tag. Accesses beyond DEPTH never touch the RAM and read as 0.
// Revision : 1.0 - initial release
// ============================================================================
module onchip_mem_arbiter
  import onchip_mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int MAX_RUN = DEF_MAX_RUN
) (
  input  logic                clk,
  input  logic                reset,
  // master 0
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  // master 1
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  // RAM side
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int          BE_W    = DATA_W / 8;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  logic                w_req0;
  logic                w_req1;
  owner_e              w_grant;
  logic                w_gnt;
  logic                w_sel1;
  logic [ADDR_W-1:0]   w_addr;
  logic [BE_W-1:0]     w_be;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_wr;
  logic                w_in_range;
  logic                w_rdv0;
  logic                w_rdv1;
  rd_tag_t             tag_q, tag_d;

  // A master requests on read or write; write takes precedence if both
  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  onchip_mem_rr_grant #(
    .MAX_RUN (MAX_RUN)
  ) u_grant (
    .clk     (clk),
    .reset   (reset),
    .req0_i  (w_req0),
    .req1_i  (w_req1),
    .grant_o (w_grant)
  );

  assign w_gnt  = (w_grant != OWN_NONE);
  assign w_sel1 = (w_grant == OWN_M1);

  // Select the granted master's command fields
  always_comb begin
    w_addr  = m0_address;
    w_be    = m0_byteenable;
    w_wdata = m0_writedata;
    w_wr    = m0_write;
    if (w_sel1) begin
      w_addr  = m1_address;
      w_be    = m1_byteenable;
      w_wdata = m1_writedata;
      w_wr    = m1_write;
    end
  end

  // Only the first DEPTH words exist; anything above is silently absorbed
  assign w_in_range = (32'(w_addr) < DEPTH_U);

  // RAM command: quiet when nobody is granted
  assign mem_address    = w_gnt ? w_addr  : '0;
  assign mem_byteenable = w_gnt ? w_be    : '0;
  assign mem_writedata  = w_gnt ? w_wdata : '0;
  assign mem_write      = w_gnt & w_wr;
  assign mem_chipselect = w_gnt & w_in_range;
  assign mem_clken      = 1'b1;

  // Stall whichever requester did not get the port this cycle
  assign m0_waitrequest = w_req0 & (w_grant != OWN_M0);
  assign m1_waitrequest = w_req1 & (w_grant != OWN_M1);

  // Tag for the read whose data comes back from the RAM next cycle
  always_comb begin
    tag_d     = '0;
    tag_d.vld = w_gnt & ~w_wr;
    tag_d.id  = w_sel1;
    tag_d.oor = ~w_in_range;
  end

  // Read tag register; reset drops any read in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  // Return path; masking with reset keeps a read granted just before
  // reset from producing a pulse during the reset cycle
  assign w_rdv0 = tag_q.vld & ~tag_q.id & ~reset;
  assign w_rdv1 = tag_q.vld &  tag_q.id & ~reset;

  assign m0_readdatavalid = w_rdv0;
  assign m1_readdatavalid = w_rdv1;
  assign m0_readdata      = (w_rdv0 & ~tag_q.oor) ? mem_readdata : '0;
  assign m1_readdata      = (w_rdv1 & ~tag_q.oor) ? mem_readdata : '0;

endmodule : onchip_mem_arbiter
`default_nettype wire
